// File: rtl/req_debounce4_pkg.sv
`default_nettype none
// ============================================================================
// Module  : req_debounce_pkg
// Brief   : Shared constants and line-vector type for the req_debounce4 slice.
// Rev     : 1.0  initial release
// ============================================================================
package req_debounce_pkg;

    localparam int unsigned NUM_LINES           = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_CNT_W           = 3;

    typedef logic [NUM_LINES-1:0] line_vec_t;

    function automatic logic any_set(input line_vec_t v);
        return |v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/req_debounce4_if.sv
`default_nettype none
// ============================================================================
// Module  : req_debounce4_if
// Brief   : Raw request lines in, debounced levels and change pulse out.
//           clr exists only when STICKY_REQ_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
interface req_debounce4_if;

    logic b3;
    logic b2;
    logic b1;
    logic b0;
    logic y3;
    logic y2;
    logic y1;
    logic y0;
    logic chg;
`ifdef STICKY_REQ_EN
    logic clr;

    modport master (
        output b3, b2, b1, b0, clr,
        input  y3, y2, y1, y0, chg
    );

    modport slave (
        input  b3, b2, b1, b0, clr,
        output y3, y2, y1, y0, chg
    );
`else
    modport master (
        output b3, b2, b1, b0,
        input  y3, y2, y1, y0, chg
    );

    modport slave (
        input  b3, b2, b1, b0,
        output y3, y2, y1, y0, chg
    );
`endif

endinterface
`default_nettype wire

// File: rtl/req_debounce4_deb_line.sv
`default_nettype none
// ============================================================================
// Module  : deb_line
// Brief   : One request line: 2-flop synchroniser, stability counter and
//           debounced level register with a same-edge update flag.
// Rev     : 1.0  initial release
// ============================================================================
module deb_line
    import req_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_b,
    output logic      o_lvl,
    output logic      o_upd
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s1_d;
    logic             s2_q;
    logic             s2_d;
    logic             lvl_q;
    logic             lvl_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_upd;

    always_comb begin
        s1_d  = i_b;
        s2_d  = s1_q;
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        w_upd = 1'b0;
        // Any agreement with the current level discards all progress.
        if (s2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == c_cnt_last) begin
            lvl_d = s2_q;
            cnt_d = '0;
            w_upd = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_lvl = lvl_q;
    assign o_upd = w_upd;

endmodule
`default_nettype wire

// File: rtl/req_debounce4.sv
`default_nettype none
// ============================================================================
// Module  : req_debounce4
// Brief   : Four independent debounced request lines feeding the 4-to-2
//           priority encoder; chg pulses once per edge where any y changed.
//           Optional macro STICKY_REQ_EN: y latches rises until clr.
// Rev     : 1.0  initial release
// ============================================================================
module req_debounce4
    import req_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  wire logic      clk,
    input  wire logic      rst,
    req_debounce4_if.slave bus
);

    line_vec_t w_b;
    line_vec_t w_lvl;
    line_vec_t w_upd;
    line_vec_t w_y;
    logic      chg_q;
    logic      chg_d;

    assign w_b = {bus.b3, bus.b2, bus.b1, bus.b0};

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
            deb_line #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_deb (
                .clk   (clk),
                .rst   (rst),
                .i_b   (w_b[gi]),
                .o_lvl (w_lvl[gi]),
                .o_upd (w_upd[gi])
            );
        end
    endgenerate

`ifdef STICKY_REQ_EN
    line_vec_t y_q;
    line_vec_t y_d;

    // Rises are OR'd in after the clear so a coincident rise survives clr.
    always_comb begin
        y_d = y_q;
        if (bus.clr) begin
            y_d = '0;
        end
        y_d   = y_d | (w_upd & ~w_lvl);
        chg_d = any_set(y_d ^ y_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign w_y = y_q;
`else
    always_comb begin
        chg_d = any_set(w_upd);
    end

    assign w_y = w_lvl;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign bus.y3  = w_y[3];
    assign bus.y2  = w_y[2];
    assign bus.y1  = w_y[1];
    assign bus.y0  = w_y[0];
    assign bus.chg = chg_q;

endmodule
`default_nettype wire

// File: tb/tb_req_debounce4.sv
`default_nettype none
// ============================================================================
// Module  : tb_req_debounce4
// Brief   : Bench for req_debounce4: window-rule reference model compared
//           every cycle, directed literal expectations, random stimulus.
// Rev     : 1.0  initial release
// ============================================================================
module tb_req_debounce4;

    localparam int DEB  = 4;
    localparam int MAXE = 8192;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] b_drv = 4'h0;
    logic [3:0] y_dut;
`ifdef STICKY_REQ_EN
    logic       clr_drv = 1'b0;
`endif

    int n_checks = 0;
    int n_err    = 0;

    req_debounce4_if bus ();

    assign bus.b3 = b_drv[3];
    assign bus.b2 = b_drv[2];
    assign bus.b1 = b_drv[1];
    assign bus.b0 = b_drv[0];
`ifdef STICKY_REQ_EN
    assign bus.clr = clr_drv;
`endif
    assign y_dut = {bus.y3, bus.y2, bus.y1, bus.y0};

    req_debounce4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: y flips at edge n when the synchronised value seen
    // at the last DEB edges all differ from y and no flip/reset occurred
    // inside that window.
    logic [3:0] cap  [0:MAXE-1];
    bit         rstf [0:MAXE-1];
    int         n = 0;
    int         last_upd [4];
    logic [3:0] lvl_m = 4'h0;
    logic [3:0] y_m   = 4'h0;
    logic       chg_m = 1'b0;

    function automatic logic [3:0] s2pre(input int m);
        if (m < 2) return 4'h0;
        if (rstf[m-1]) return 4'h0;
        return cap[m-2];
    endfunction

    always @(posedge clk) begin : model_cmp
        logic [3:0] rise_v;
        logic [3:0] win;
        bit         all_mis;
        n++;
        if (n >= MAXE) begin
            $display("FAIL edge_budget: got %0d edges expected below %0d", n, MAXE);
            $fatal(1);
        end
        rstf[n] = rst;
        cap[n]  = rst ? 4'h0 : b_drv;
        if (rst) begin
            lvl_m = 4'h0;
            y_m   = 4'h0;
            chg_m = 1'b0;
            for (int i = 0; i < 4; i++) last_upd[i] = n;
        end else begin
            rise_v = 4'h0;
            chg_m  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (n - last_upd[i] >= DEB) begin
                    all_mis = 1'b1;
                    for (int j = 0; j < DEB; j++) begin
                        win = s2pre(n - j);
                        if (win[i] == lvl_m[i]) all_mis = 1'b0;
                    end
                    if (all_mis) begin
                        if (!lvl_m[i]) rise_v[i] = 1'b1;
                        lvl_m[i]    = ~lvl_m[i];
                        last_upd[i] = n;
                        chg_m       = 1'b1;
                    end
                end
            end
`ifdef STICKY_REQ_EN
            begin
                logic [3:0] y_new;
                y_new = (clr_drv ? 4'h0 : y_m) | rise_v;
                chg_m = (y_new != y_m);
                y_m   = y_new;
            end
`else
            y_m = lvl_m;
`endif
        end
        #1;
        chk("model_y", y_dut, y_m);
        chk("model_chg", {3'b000, bus.chg}, {3'b000, chg_m});
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Return all lines to 0 and (sticky build) clear latched requests.
    task automatic settle();
        b_drv = 4'h0;
        step(12);
`ifdef STICKY_REQ_EN
        clr_drv = 1'b1;
        step(1);
        clr_drv = 1'b0;
        step(1);
`endif
        chk("settle_y", y_dut, 4'h0);
    endtask

    initial begin
        rst   = 1'b1;
        b_drv = 4'hF;
        step(3);
        chk("rst_y", y_dut, 4'h0);
        chk("rst_chg", {3'b000, bus.chg}, 4'h0);
        rst = 1'b0;
        step(5);
        chk("rel_y_e4", y_dut, 4'h0);
        step(1);
        chk("rel_y_e5", y_dut, 4'hF);
        chk("rel_chg", {3'b000, bus.chg}, 4'h1);
        step(1);
        chk("rel_chg_off", {3'b000, bus.chg}, 4'h0);
        settle();

        // Clean rise on b1.
        b_drv = 4'b0010;
        step(5);
        chk("rise_y_e4", y_dut, 4'h0);
        step(1);
        chk("rise_y_e5", y_dut, 4'b0010);
        chk("rise_chg", {3'b000, bus.chg}, 4'h1);
        step(1);
        chk("rise_chg_off", {3'b000, bus.chg}, 4'h0);

        // Short pulse on b2 is rejected, long one passes.
        b_drv = 4'b0110;
        step(2);
        b_drv = 4'b0010;
        step(10);
        chk("glitch_y", y_dut, 4'b0010);
        b_drv = 4'b0110;
        step(6);
        chk("long_y", y_dut, 4'b0110);
        step(1);

        // b3 and b0 together: one pulse.
        b_drv = 4'b1111;
        step(6);
        chk("simul_y", y_dut, 4'b1111);
        chk("simul_chg", {3'b000, bus.chg}, 4'h1);
        step(1);
        chk("simul_chg_off", {3'b000, bus.chg}, 4'h0);
        settle();

        // Reset while b0 count is in progress.
        b_drv = 4'b0001;
        step(4);
        rst = 1'b1;
        step(1);
        chk("midrst_y", y_dut, 4'h0);
        rst = 1'b0;
        step(5);
        chk("midrst_y_e4", y_dut, 4'h0);
        step(1);
        chk("midrst_y_e5", y_dut, 4'b0001);
        settle();

`ifdef STICKY_REQ_EN
        b_drv = 4'b0010;
        step(7);
        b_drv = 4'b0000;
        step(8);
        chk("sticky_hold", y_dut, 4'b0010);
        clr_drv = 1'b1;
        step(1);
        clr_drv = 1'b0;
        chk("sticky_clr_y", y_dut, 4'h0);
        chk("sticky_clr_chg", {3'b000, bus.chg}, 4'h1);
        b_drv = 4'b0100;
        step(5);
        clr_drv = 1'b1;
        step(1);
        clr_drv = 1'b0;
        chk("clr_vs_rise", y_dut, 4'b0100);
        settle();
`endif

        // Random phase: sparse toggles, occasional reset (and clr).
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) b_drv[i] = ~b_drv[i];
            end
            rst = ($urandom_range(299) == 0);
`ifdef STICKY_REQ_EN
            clr_drv = ($urandom_range(24) == 0);
`endif
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL timeout: got no finish expected finish before 500us");
        $fatal(1);
    end

endmodule
`default_nettype wire
